util_axis_count_checker: RTL and testbench

AXI-Stream sink that consumes a counting-pattern stream, such as the read side of util_axis_xfifo, and verifies it. It drives tready with selectable backpressure (always-ready or LFSR pseudo-random). Each accepted beat is checked for a +1 increment modulo the bus width, and optionally for tlast position. Beats and errors are counted in status outputs for bring-up and loopback tests.

---
 rtl/util_axis_count_checker_pkg.sv | 31 +++
 rtl/util_axis_count_checker_if.sv | 31 +++
 rtl/util_axis_count_checker_lfsr16.sv | 30 +++
 rtl/util_axis_count_checker.sv | 128 ++++++++++++
 tb/tb_util_axis_count_checker.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/util_axis_count_checker_pkg.sv
// Shared types, constants and helpers for the AXI-Stream counting-pattern checker.
//   state_t       : checker FSM states
//   LFSR_TAPS     : 16-bit Fibonacci LFSR tap mask (x^16 + x^14 + x^13 + x^11 + 1)
//   sat_inc()     : saturating increment for counters up to 64 bits wide
package util_axis_count_checker_pkg;

    typedef enum logic [0:0] {
        SYNC  = 1'b0,
        CHECK = 1'b1
    } state_t;

    // Bits 15, 13, 12 and 10 feed back into bit 0.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int unsigned SAT_MAX_WIDTH = 64;

    // Increment value, holding at all-ones of the given width.
    function automatic logic [SAT_MAX_WIDTH-1:0] sat_inc(
        input logic [SAT_MAX_WIDTH-1:0] value,
        input int unsigned              width
    );
        logic [SAT_MAX_WIDTH-1:0] max_val;
        if (width >= SAT_MAX_WIDTH) begin
            max_val = '1;
        end else begin
            max_val = (SAT_MAX_WIDTH'(1) << width) - SAT_MAX_WIDTH'(1);
        end
        return (value >= max_val) ? value : value + SAT_MAX_WIDTH'(1);
    endfunction

endpackage

// File: rtl/util_axis_count_checker_if.sv
// AXI-Stream handshake/payload bundle.
//   tvalid/tdata/tlast : source -> sink
//   tready             : sink -> source
//   master modport     : stream source
//   slave modport      : stream sink
interface util_axis_count_checker_if #(
    parameter int unsigned BUS_WIDTH = 1
) ();

    localparam int unsigned DW = 8 * BUS_WIDTH;

    logic          tvalid;
    logic          tready;
    logic [DW-1:0] tdata;
    logic          tlast;

    modport master (
        output tvalid,
        output tdata,
        output tlast,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        input  tlast,
        output tready
    );

endinterface

// File: rtl/util_axis_count_checker_lfsr16.sv
// 16-bit Fibonacci LFSR, shifting toward the MSB with feedback into bit 0.
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset, loads SEED
//   en      : advance one step this cycle
//   out_bit : bit 0 of the current state
//   state   : full current state (never zero for a nonzero SEED)
module util_lfsr16
    import util_axis_count_checker_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        out_bit,
    output logic [15:0] state
);

    // Step the register; XOR of the tapped bits enters at the bottom.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SEED;
        end else if (en) begin
            state <= {state[14:0], ^(state & LFSR_TAPS)};
        end
    end

    assign out_bit = state[0];

endmodule

// File: rtl/util_axis_count_checker.sv
// AXI-Stream sink that checks a +1 counting pattern and optional tlast framing.
//   aclk, rst        : clock and synchronous active-high reset
//   enable           : run the checker; when low tready drops and all state holds
//   clear            : one-cycle pulse, zeroes counters/errors and returns to SYNC
//   s_axis           : stream input (slave modport)
//   beat_count       : accepted beats, saturating
//   data_err_count   : data mismatches, saturating
//   last_err_count   : tlast position mismatches, saturating
//   err_sticky       : any error seen since rst/clear
//   err_data         : tdata of the first mismatching beat
//   locked           : high while in CHECK
module util_axis_count_checker
    import util_axis_count_checker_pkg::*;
#(
    parameter int unsigned BUS_WIDTH   = 1,
    parameter int unsigned COUNT_WIDTH = 32,
    parameter int unsigned READY_MODE  = 0,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter int unsigned PACKET_LEN  = 0
) (
    input  logic                     aclk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     clear,
    util_axis_count_checker_if.slave s_axis,
    output logic [COUNT_WIDTH-1:0]   beat_count,
    output logic [COUNT_WIDTH-1:0]   data_err_count,
    output logic [COUNT_WIDTH-1:0]   last_err_count,
    output logic                     err_sticky,
    output logic [8*BUS_WIDTH-1:0]   err_data,
    output logic                     locked
);

    localparam int unsigned DW       = 8 * BUS_WIDTH;
    localparam int unsigned PW       = (PACKET_LEN > 0) ? $clog2(PACKET_LEN + 1) : 1;
    localparam int unsigned LAST_POS = (PACKET_LEN > 0) ? PACKET_LEN - 1 : 0;

    state_t        state;
    logic [DW-1:0] expected;
    logic [PW-1:0] pos;
    logic          tready_q;

    logic          lfsr_bit;
    logic [15:0]   lfsr_state;
    logic          unused_lfsr;

    logic          accept;
    logic          at_last;
    logic          data_bad;
    logic          last_bad;
    logic          ready_next;

    // Pseudo-random backpressure source, stepped only while enabled.
    util_lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk     (aclk),
        .rst     (rst),
        .en      (enable),
        .out_bit (lfsr_bit),
        .state   (lfsr_state)
    );

    assign unused_lfsr = ^lfsr_state;

    assign s_axis.tready = tready_q;

    // Handshake and per-beat error decisions.
    assign accept     = s_axis.tvalid & tready_q;
    assign at_last    = (pos == PW'(LAST_POS));
    assign data_bad   = (state == CHECK) && (s_axis.tdata != expected);
    assign last_bad   = (PACKET_LEN != 0) && (s_axis.tlast != at_last);
    assign ready_next = enable & ((READY_MODE != 0) ? lfsr_bit : 1'b1);

    // Checker FSM, counters and status registers.
    always_ff @(posedge aclk) begin
        if (rst) begin
            state          <= SYNC;
            expected       <= '0;
            pos            <= '0;
            tready_q       <= 1'b0;
            beat_count     <= '0;
            data_err_count <= '0;
            last_err_count <= '0;
            err_sticky     <= 1'b0;
            err_data       <= '0;
            locked         <= 1'b0;
        end else begin
            // tready keeps following enable/LFSR even during clear so the
            // source sees no extra bubble.
            tready_q <= ready_next;

            if (clear) begin
                state          <= SYNC;
                pos            <= '0;
                beat_count     <= '0;
                data_err_count <= '0;
                last_err_count <= '0;
                err_sticky     <= 1'b0;
                err_data       <= '0;
                locked         <= 1'b0;
            end else if (accept) begin
                beat_count <= COUNT_WIDTH'(sat_inc(SAT_MAX_WIDTH'(beat_count), COUNT_WIDTH));
                // Resync on every beat so one glitch yields one error.
                expected   <= s_axis.tdata + DW'(1);
                state      <= CHECK;
                locked     <= 1'b1;
                pos        <= at_last ? '0 : pos + PW'(1);

                if (data_bad) begin
                    data_err_count <= COUNT_WIDTH'(sat_inc(SAT_MAX_WIDTH'(data_err_count), COUNT_WIDTH));
                    if (!err_sticky) begin
                        err_data <= s_axis.tdata;
                    end
                end

                if (last_bad) begin
                    last_err_count <= COUNT_WIDTH'(sat_inc(SAT_MAX_WIDTH'(last_err_count), COUNT_WIDTH));
                end

                if (data_bad || last_bad) begin
                    err_sticky <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_util_axis_count_checker.sv
// Directed self-checking bench: three checker instances (always-ready,
// LFSR backpressure, 4-beat packets with narrow saturating counters)
// share clock/reset/enable/clear; a selector routes the stream source.
module tb_util_axis_count_checker;

    localparam int unsigned CW0 = 32;
    localparam int unsigned CW2 = 3;
    localparam int          WAIT_LIMIT = 100;

    logic aclk;
    logic rst;
    logic enable;
    logic clear;

    logic       src_valid;
    logic [7:0] src_data;
    logic       src_last;
    int         sel;
    logic       cur_ready;

    int n_checks;
    int n_fails;
    int ready_hi;
    int ready_lo;

    util_axis_count_checker_if #(.BUS_WIDTH(1)) if0 ();
    util_axis_count_checker_if #(.BUS_WIDTH(1)) if1 ();
    util_axis_count_checker_if #(.BUS_WIDTH(1)) if2 ();

    logic [CW0-1:0] beat0, derr0, lerr0;
    logic           sticky0, locked0;
    logic [7:0]     edata0;
    logic [CW0-1:0] beat1, derr1, lerr1;
    logic           sticky1, locked1;
    logic [7:0]     edata1;
    logic [CW2-1:0] beat2, derr2, lerr2;
    logic           sticky2, locked2;
    logic [7:0]     edata2;

    assign if0.tvalid = src_valid && (sel == 0);
    assign if1.tvalid = src_valid && (sel == 1);
    assign if2.tvalid = src_valid && (sel == 2);
    assign if0.tdata  = src_data;
    assign if1.tdata  = src_data;
    assign if2.tdata  = src_data;
    assign if0.tlast  = src_last;
    assign if1.tlast  = src_last;
    assign if2.tlast  = src_last;

    always_comb begin
        case (sel)
            0:       cur_ready = if0.tready;
            1:       cur_ready = if1.tready;
            default: cur_ready = if2.tready;
        endcase
    end

    util_axis_count_checker #(
        .BUS_WIDTH(1), .COUNT_WIDTH(CW0), .READY_MODE(0),
        .LFSR_SEED(16'hACE1), .PACKET_LEN(0)
    ) u0 (
        .aclk(aclk), .rst(rst), .enable(enable), .clear(clear), .s_axis(if0.slave),
        .beat_count(beat0), .data_err_count(derr0), .last_err_count(lerr0),
        .err_sticky(sticky0), .err_data(edata0), .locked(locked0)
    );

    util_axis_count_checker #(
        .BUS_WIDTH(1), .COUNT_WIDTH(CW0), .READY_MODE(1),
        .LFSR_SEED(16'hACE1), .PACKET_LEN(0)
    ) u1 (
        .aclk(aclk), .rst(rst), .enable(enable), .clear(clear), .s_axis(if1.slave),
        .beat_count(beat1), .data_err_count(derr1), .last_err_count(lerr1),
        .err_sticky(sticky1), .err_data(edata1), .locked(locked1)
    );

    util_axis_count_checker #(
        .BUS_WIDTH(1), .COUNT_WIDTH(CW2), .READY_MODE(0),
        .LFSR_SEED(16'hACE1), .PACKET_LEN(4)
    ) u2 (
        .aclk(aclk), .rst(rst), .enable(enable), .clear(clear), .s_axis(if2.slave),
        .beat_count(beat2), .data_err_count(derr2), .last_err_count(lerr2),
        .err_sticky(sticky2), .err_data(edata2), .locked(locked2)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Observe backpressure pattern of the LFSR instance while it is selected.
    always @(negedge aclk) begin
        if (sel == 1) begin
            if (if1.tready) ready_hi++;
            else            ready_lo++;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one beat from just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [7:0] d, input logic l);
        int n;
        n = 0;
        src_valid = 1'b1;
        src_data  = d;
        src_last  = l;
        @(negedge aclk);
        while (!cur_ready && n < WAIT_LIMIT) begin
            @(negedge aclk);
            n++;
        end
        if (n >= WAIT_LIMIT) check("ready_timeout", 64'(n), 64'(0));
        @(posedge aclk);
        #1;
        src_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_fails   = 0;
        ready_hi  = 0;
        ready_lo  = 0;
        rst       = 1'b1;
        enable    = 1'b0;
        clear     = 1'b0;
        src_valid = 1'b0;
        src_data  = 8'h00;
        src_last  = 1'b0;
        sel       = 0;

        repeat (3) tick();

        // Reset state.
        check("rst_tready", 64'(if0.tready), 64'(0));
        check("rst_beat",   64'(beat0),      64'(0));
        check("rst_derr",   64'(derr0),      64'(0));
        check("rst_sticky", 64'(sticky0),    64'(0));
        check("rst_locked", 64'(locked0),    64'(0));

        // Always-ready mode, clean 0..9.
        rst    = 1'b0;
        enable = 1'b1;
        tick();
        check("ready_up", 64'(if0.tready), 64'(1));
        send(8'd0, 1'b0);
        check("lock_first", 64'(locked0), 64'(1));
        for (int i = 1; i < 10; i++) begin
            send(8'(i), 1'b0);
            check("ready_hold", 64'(if0.tready), 64'(1));
        end
        check("t1_beat", 64'(beat0), 64'(10));
        check("t1_derr", 64'(derr0), 64'(0));

        // Single glitch: 0,1,2,7,8,9.
        pulse_clear();
        send(8'd0, 1'b0);
        send(8'd1, 1'b0);
        send(8'd2, 1'b0);
        send(8'd7, 1'b0);
        send(8'd8, 1'b0);
        send(8'd9, 1'b0);
        check("t2_derr",   64'(derr0),   64'(1));
        check("t2_edata",  64'(edata0),  64'(8'h07));
        check("t2_sticky", 64'(sticky0), 64'(1));
        check("t2_beat",   64'(beat0),   64'(6));

        // Clear concurrent with a beat wins, then resync on 0x55.
        clear = 1'b1;
        send(8'h20, 1'b0);
        clear = 1'b0;
        check("clr_beat",   64'(beat0),   64'(0));
        check("clr_derr",   64'(derr0),   64'(0));
        check("clr_sticky", 64'(sticky0), 64'(0));
        check("clr_edata",  64'(edata0),  64'(0));
        check("clr_locked", 64'(locked0), 64'(0));
        send(8'h55, 1'b0);
        send(8'h56, 1'b0);
        check("resync_beat", 64'(beat0), 64'(2));
        check("resync_derr", 64'(derr0), 64'(0));

        // Wrap FD..02 is clean.
        pulse_clear();
        send(8'hFD, 1'b0);
        send(8'hFE, 1'b0);
        send(8'hFF, 1'b0);
        send(8'h00, 1'b0);
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        check("wrap_beat", 64'(beat0), 64'(6));
        check("wrap_derr", 64'(derr0), 64'(0));

        // enable low: tready falls, state held, no return to SYNC.
        enable = 1'b0;
        tick();
        tick();
        check("dis_tready", 64'(if0.tready), 64'(0));
        check("dis_beat",   64'(beat0),      64'(6));
        check("dis_locked", 64'(locked0),    64'(1));
        enable = 1'b1;
        tick();
        send(8'h03, 1'b0);
        check("reen_beat", 64'(beat0), 64'(7));
        check("reen_derr", 64'(derr0), 64'(0));

        // Error, then reset with a beat present.
        send(8'h07, 1'b0);
        check("pre_rst_derr", 64'(derr0), 64'(1));
        rst = 1'b1;
        send(8'h10, 1'b0);
        rst = 1'b0;
        check("mid_rst_tready", 64'(if0.tready), 64'(0));
        check("mid_rst_beat",   64'(beat0),      64'(0));
        check("mid_rst_derr",   64'(derr0),      64'(0));
        check("mid_rst_sticky", 64'(sticky0),    64'(0));
        check("mid_rst_edata",  64'(edata0),     64'(0));
        check("mid_rst_locked", 64'(locked0),    64'(0));

        // LFSR backpressure, 200 beats with random source gaps.
        tick();
        sel = 1;
        for (int i = 0; i < 200; i++) begin
            send(8'(i), 1'b0);
            repeat ($urandom_range(0, 2)) tick();
        end
        check("lfsr_beat",    64'(beat1),   64'(200));
        check("lfsr_derr",    64'(derr1),   64'(0));
        check("lfsr_sticky",  64'(sticky1), 64'(0));
        check("lfsr_toggles", 64'((ready_hi > 0) && (ready_lo > 0)), 64'(1));

        // 4-beat packets: tlast on beats 3 and 7, missing on 11; 3-bit counters saturate.
        sel = 2;
        pulse_clear();
        for (int i = 0; i < 12; i++) begin
            send(8'(i), (i == 3) || (i == 7));
        end
        check("pkt_lerr",   64'(lerr2),   64'(1));
        check("pkt_derr",   64'(derr2),   64'(0));
        check("pkt_beat",   64'(beat2),   64'(7));
        check("pkt_sticky", 64'(sticky2), 64'(1));
        check("pkt_edata",  64'(edata2),  64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    // Hard stop in case a wait escapes its bound.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
